// File: rtl/register_file_pkg.sv
// Shared LegV8 register-file constants: register count, zero-register index
// and address width.
package register_file_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR_INDEX = REG_ADDR_W'(31);
endpackage

// File: rtl/register_file.sv
// LegV8 register file: 31 writable registers plus a hardwired-zero XZR,
// with two combinational read ports and optional write-through forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int N      = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic [N-1:0]          write_data,
  input  logic [REG_ADDR_W-1:0] read_addr_a,
  input  logic [REG_ADDR_W-1:0] read_addr_b,
  output logic [N-1:0]          read_data_a,
  output logic [N-1:0]          read_data_b
);

  logic [N-1:0] regs [0:REG_COUNT-2];
  logic         write_valid;

  assign write_valid = write_enable && (write_addr != XZR_INDEX);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (write_valid) begin
      regs[write_addr] <= write_data;
    end
  end

  // Forwarding is suppressed under reset because the coincident write is dropped.
  always_comb begin
    read_data_a = '0;
    if (read_addr_a != XZR_INDEX) begin
      if (BYPASS && !reset && write_valid && (write_addr == read_addr_a)) begin
        read_data_a = write_data;
      end else begin
        read_data_a = regs[read_addr_a];
      end
    end
  end

  always_comb begin
    read_data_b = '0;
    if (read_addr_b != XZR_INDEX) begin
      if (BYPASS && !reset && write_valid && (write_addr == read_addr_b)) begin
        read_data_b = write_data;
      end else begin
        read_data_b = regs[read_addr_b];
      end
    end
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 64, data width of every register and data port.
REQ-002 Parameter BYPASS, default 1; 1 = write-through forwarding on reads, 0 = reads return stored value only.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 write_enable  input  1  1 = commit write_data into register write_addr at next rising edge.
REQ-006 write_addr  input  5  destination register index 0..31.
REQ-007 write_data  input  N  data to be written.
REQ-008 read_addr_a  input  5  source register index for port A.
REQ-009 read_addr_b  input  5  source register index for port B.
REQ-010 read_data_a  output  N  port A data; feeds the N-bit 8-to-1 operand select mux downstream.
REQ-011 read_data_b  output  N  port B data; feeds the N-bit 8-to-1 operand select mux downstream.

Function
REQ-012 Storage SHALL be 31 writable N-bit registers X0..X30; index 31 (XZR) SHALL have no storage.
REQ-013 Reads SHALL be combinational: read_data_x reflects the addressed register in the same cycle, zero clock latency.
REQ-014 Any read of index 31 SHALL return all zeros, regardless of BYPASS, write_enable or write_addr.
REQ-015 Write with write_enable=1 and write_addr in 0..30 SHALL update that register at the rising edge; the new value is visible from the following cycle.
REQ-016 Write with write_addr=31 SHALL be discarded; no register changes.
REQ-017 write_enable=0 SHALL leave all registers unchanged, whatever write_addr/write_data hold.
REQ-018 BYPASS=1: if write_enable=1, write_addr=read_addr_x and write_addr!=31, read_data_x SHALL equal write_data in that same cycle.
REQ-019 BYPASS=0: same condition SHALL return the pre-edge stored value until the edge.
REQ-020 Both ports SHALL be independent; A and B may address the same register simultaneously and both return identical data.
REQ-021 Exactly one write per cycle; no partial-width writes; no read side effects.
REQ-022 Outputs SHALL never be X/undefined after the first reset edge for any legal 5-bit address.

Reset
REQ-023 reset=1 at a rising edge SHALL clear X0..X30 to zero; reset takes priority over a coincident write, which is dropped.
REQ-024 While reset is asserted, reads SHALL return the current stored contents (zero after the first reset edge); with BYPASS=1, forwarding SHALL be suppressed while reset=1.
REQ-025 Reset deasserted mid-sequence SHALL require no recovery cycle; a write in the first cycle after reset commits normally.

Structure
REQ-026 Constants REG_COUNT=32, XZR_INDEX=31 and REG_ADDR_W=5 SHALL live in the shared LegV8 constants package/include, not locally.
REQ-027 No sub-module; storage is one register array with inline write decode and two read selects.
REQ-028 No internal state beyond the 31 registers; no FSM.

Verification
REQ-029 Reset then read all 32 indices on both ports -> every read_data = 0.
REQ-030 Write X5=0x0123456789ABCDEF, next cycle read_addr_a=5, read_addr_b=5 -> both ports 0x0123456789ABCDEF.
REQ-031 Write X31=0xFFFFFFFFFFFFFFFF with read_addr_a=31 -> read_data_a=0 same cycle and next cycle; X0..X30 unchanged.
REQ-032 BYPASS=1, X7 holds 0x11, write X7=0x22 with read_addr_a=7 -> read_data_a=0x22 before edge; BYPASS=0 -> 0x11 before edge, 0x22 after.
REQ-033 X3=0xAA; assert reset with write X3=0x55 same cycle -> X3=0 after edge, not 0x55; write X3=0x77 in first post-reset cycle -> X3=0x77.
REQ-034 write_enable=0, write_addr=9, write_data=0xDEAD for 4 cycles -> X9 keeps prior value 0x99.
